// File: rtl/dual_issue_ctrl_pkg.sv
// Shared constants and decode payload for the dual-issue decode/issue stage.
package dual_issue_ctrl_pkg;

    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned IW_DEF    = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned NREG      = 2 ** REG_W;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 26;
    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;
    localparam int unsigned RD_MSB = 15;
    localparam int unsigned RD_LSB = 11;

    // Register usage of one instruction as seen by the hazard logic.
    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             has_dest;
        logic [REG_W-1:0] src_a;
        logic             src_a_vld;
        logic [REG_W-1:0] src_b;
        logic             src_b_vld;
        logic             is_ctrl;
    } dec_t;

endpackage

// File: rtl/dual_issue_ctrl_instr_field_decode.sv
// Combinational register-field decode of one MIPS instruction.
module instr_field_decode
    import dual_issue_ctrl_pkg::*;
#(
    parameter int unsigned IW = IW_DEF
) (
    input  logic [IW-1:0] instr,
    output dec_t          dec
);

    logic [5:0]       op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;

    assign op = instr[OP_MSB:OP_LSB];
    assign rs = instr[RS_MSB:RS_LSB];
    assign rt = instr[RT_MSB:RT_LSB];
    assign rd = instr[RD_MSB:RD_LSB];

    // Classify by opcode; writes to $0 are not tracked.
    always_comb begin
        dec = '0;
        case (op)
            OP_RTYPE: begin
                dec.dest      = rd;
                dec.has_dest  = 1'b1;
                dec.src_a     = rs;
                dec.src_a_vld = 1'b1;
                dec.src_b     = rt;
                dec.src_b_vld = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                dec.src_a     = rs;
                dec.src_a_vld = 1'b1;
                dec.src_b     = rt;
                dec.src_b_vld = 1'b1;
                dec.is_ctrl   = (op != OP_SW);
            end
            OP_J: begin
                dec.is_ctrl = 1'b1;
            end
            default: begin
                dec.dest      = rt;
                dec.has_dest  = 1'b1;
                dec.src_a     = rs;
                dec.src_a_vld = 1'b1;
            end
        endcase
        if (dec.dest == '0) begin
            dec.has_dest = 1'b0;
        end
    end

endmodule

// File: rtl/dual_issue_ctrl.sv
// Dual-issue decode/issue stage: in-order queue, scoreboard, pair-issue check.
module dual_issue_ctrl
    import dual_issue_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned IW    = IW_DEF,
    parameter int unsigned RW    = REG_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [1:0]    i_fs_ce,
    input  logic [IW-1:0] i_fs_instr0,
    input  logic [IW-1:0] i_fs_instr1,
    output logic          o_fs_ready,
    input  logic          i_es_stall,
    input  logic          i_flush,
    input  logic          i_cd1_we,
    input  logic [RW-1:0] i_cd1_rd,
    input  logic          i_cd2_we,
    input  logic [RW-1:0] i_cd2_rd,
    output logic          ds1_es1_o_ce,
    output logic          ds2_es2_o_ce,
    output logic [IW-1:0] o_es1_instr,
    output logic [IW-1:0] o_es2_instr
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [IW-1:0]   mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;

    logic [IW-1:0]   head_instr;
    logic [IW-1:0]   next_instr;
    dec_t            dec_a;
    dec_t            dec_b;

    logic            push_ok;
    logic [CW-1:0]   n_push;
    logic [CW-1:0]   n_pop;
    logic            issue_a;
    logic            issue_b;
    logic            blk_a;
    logic            blk_b;
    logic            raw_b;
    logic            waw_b;

    assign o_fs_ready = (count <= CW'(DEPTH - 2));
    assign head_instr = mem[rd_ptr];
    assign next_instr = mem[rd_ptr + PW'(1)];

    instr_field_decode #(.IW(IW)) u_dec_a (.instr(head_instr), .dec(dec_a));
    instr_field_decode #(.IW(IW)) u_dec_b (.instr(next_instr), .dec(dec_b));

    // Issue decision for the head pair against the scoreboard and each other.
    always_comb begin
        blk_a   = 1'b0;
        blk_b   = 1'b0;
        raw_b   = 1'b0;
        waw_b   = 1'b0;
        issue_a = 1'b0;
        issue_b = 1'b0;
        blk_a   = (dec_a.src_a_vld && sb[dec_a.src_a]) ||
                  (dec_a.src_b_vld && sb[dec_a.src_b]);
        blk_b   = (dec_b.src_a_vld && sb[dec_b.src_a]) ||
                  (dec_b.src_b_vld && sb[dec_b.src_b]);
        raw_b   = dec_a.has_dest &&
                  ((dec_b.src_a_vld && (dec_b.src_a == dec_a.dest)) ||
                   (dec_b.src_b_vld && (dec_b.src_b == dec_a.dest)));
        waw_b   = dec_a.has_dest && dec_b.has_dest && (dec_b.dest == dec_a.dest);
        issue_a = (count >= CW'(1)) && !i_es_stall && !i_flush && !blk_a;
        issue_b = issue_a && (count >= CW'(2)) && !dec_a.is_ctrl &&
                  !raw_b && !waw_b && !blk_b;
    end

    // Push/pop amounts and scoreboard update; a same-cycle set beats a clear.
    always_comb begin
        push_ok = o_fs_ready && !i_flush;
        n_push  = '0;
        n_pop   = CW'(issue_a) + CW'(issue_b);
        sb_next = sb;
        if (push_ok) begin
            n_push = CW'(i_fs_ce[0]) + CW'(i_fs_ce[1]);
        end
        if (i_cd1_we && (i_cd1_rd != '0)) begin
            sb_next[i_cd1_rd] = 1'b0;
        end
        if (i_cd2_we && (i_cd2_rd != '0)) begin
            sb_next[i_cd2_rd] = 1'b0;
        end
        if (issue_a && dec_a.has_dest) begin
            sb_next[dec_a.dest] = 1'b1;
        end
        if (issue_b && dec_b.has_dest) begin
            sb_next[dec_b.dest] = 1'b1;
        end
    end

    // Queue storage writes, older slot first.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            case (i_fs_ce)
                2'b01: mem[wr_ptr] <= i_fs_instr0;
                2'b10: mem[wr_ptr] <= i_fs_instr1;
                2'b11: begin
                    mem[wr_ptr]          <= i_fs_instr0;
                    mem[wr_ptr + PW'(1)] <= i_fs_instr1;
                end
                default: ;
            endcase
        end
    end

    // Pointers, occupancy, scoreboard and registered issue outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            sb           <= '0;
            ds1_es1_o_ce <= 1'b0;
            ds2_es2_o_ce <= 1'b0;
            o_es1_instr  <= '0;
            o_es2_instr  <= '0;
        end else begin
            if (i_flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                rd_ptr <= rd_ptr + PW'(n_pop);
                wr_ptr <= wr_ptr + PW'(n_push);
                count  <= count + n_push - n_pop;
            end
            sb           <= sb_next;
            ds1_es1_o_ce <= issue_a;
            ds2_es2_o_ce <= issue_b;
            o_es1_instr  <= issue_a ? head_instr : '0;
            o_es2_instr  <= issue_b ? next_instr : '0;
        end
    end

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Directed vector bench for dual_issue_ctrl.
module tb_dual_issue_ctrl;

    localparam logic [31:0] IA  = 32'h00221820; // add $3,$1,$2
    localparam logic [31:0] IB  = 32'h00853020; // add $6,$4,$5
    localparam logic [31:0] IC  = 32'h00612020; // add $4,$3,$1
    localparam logic [31:0] IQ  = 32'h10220003; // beq $1,$2
    localparam logic [31:0] ID  = 32'h00E84820; // add $9,$7,$8
    localparam logic [31:0] IA2 = 32'h00E81820; // add $3,$7,$8
    localparam logic [31:0] IE  = 32'h014B6020; // add $12,$10,$11
    localparam logic [31:0] IZ  = 32'h0;
    localparam logic [31:0] IF  = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  fs_ce = 2'b00;
    logic [31:0] fs_i0 = '0;
    logic [31:0] fs_i1 = '0;
    logic        fs_ready;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        cd1_we = 1'b0;
    logic [4:0]  cd1_rd = '0;
    logic        cd2_we = 1'b0;
    logic [4:0]  cd2_rd = '0;
    logic        ce1;
    logic        ce2;
    logic [31:0] es1;
    logic [31:0] es2;

    int errors = 0;
    int checks = 0;

    dual_issue_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fs_ce      (fs_ce),
        .i_fs_instr0  (fs_i0),
        .i_fs_instr1  (fs_i1),
        .o_fs_ready   (fs_ready),
        .i_es_stall   (stall),
        .i_flush      (flush),
        .i_cd1_we     (cd1_we),
        .i_cd1_rd     (cd1_rd),
        .i_cd2_we     (cd2_we),
        .i_cd2_rd     (cd2_rd),
        .ds1_es1_o_ce (ce1),
        .ds2_es2_o_ce (ce2),
        .o_es1_instr  (es1),
        .o_es2_instr  (es2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  fs;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        st;
        logic        fl;
        logic        c1;
        logic [4:0]  r1;
        logic        c2;
        logic [4:0]  r2;
        logic        e1;
        logic        e2;
        logic [31:0] o1;
        logic [31:0] o2;
        logic        rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] fs, input logic [31:0] i0, input logic [31:0] i1,
                       input logic st, input logic fl, input logic c1, input logic [4:0] r1,
                       input logic c2, input logic [4:0] r2, input logic e1, input logic e2,
                       input logic [31:0] o1, input logic [31:0] o2, input logic rdy);
        vec_t v;
        v.rst = r; v.fs = fs; v.i0 = i0; v.i1 = i1; v.st = st; v.fl = fl;
        v.c1 = c1; v.r1 = r1; v.c2 = c2; v.r2 = r2;
        v.e1 = e1; v.e2 = e2; v.o1 = o1; v.o2 = o2; v.rdy = rdy;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [1:0] fs, input logic [31:0] i0, input logic [31:0] i1,
                         input logic st, input logic fl, input logic c1, input logic [4:0] r1,
                         input logic c2, input logic [4:0] r2);
        rst = r; fs_ce = fs; fs_i0 = i0; fs_i1 = i1; stall = st; flush = fl;
        cd1_we = c1; cd1_rd = r1; cd2_we = c2; cd2_rd = r2;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e1, input logic e2,
                           input logic [31:0] o1, input logic [31:0] o2, input logic rdy);
        chk({tag, " ce1"}, 32'(ce1), 32'(e1));
        chk({tag, " ce2"}, 32'(ce2), 32'(e2));
        chk({tag, " es1"}, es1, o1);
        chk({tag, " es2"}, es2, o2);
        chk({tag, " ready"}, 32'(fs_ready), 32'(rdy));
    endtask

    initial begin
        bit found;

        // rst fs i0 i1 st fl c1 r1 c2 r2 | e1 e2 o1 o2 rdy
        add(0, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(0, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 3, IA, IB, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   1, 1, IA, IB, 1);
        // RAW pair, held until writeback clears $3
        add(0, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 3, IA, IC, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   1, 0, IA, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 1, 3, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   1, 0, IC, IZ, 1);
        // stall fills queue, third push dropped, drain wraps pointers
        add(0, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 3, IA, IB, 1, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 3, IQ, ID, 1, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 0);
        add(1, 3, IB, IB, 1, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 0);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   1, 1, IA, IB, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   1, 0, IQ, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   1, 0, ID, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        // flush with three queued and a concurrent push; scoreboard kept
        add(1, 3, IA, IB, 1, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 1, ID, IZ, 1, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 0);
        add(1, 3, IC, IQ, 1, 1, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 1, IC, IZ, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 1, 3,   0, 0, IZ, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   1, 0, IC, IZ, 1);
        // branch at head issues alone
        add(0, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 3, IQ, IB, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   1, 0, IQ, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   1, 0, IB, IZ, 1);
        // younger slot alone
        add(1, 2, IF, IA, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   1, 0, IA, IZ, 1);
        // WAW pair splits
        add(0, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   0, 0, IZ, IZ, 1);
        add(1, 3, IA, IA2, 0, 0, 0, 0, 0, 0,  0, 0, IZ, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   1, 0, IA, IZ, 1);
        add(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0,   1, 0, IA2, IZ, 1);

        foreach (vecs[n]) begin
            drive(vecs[n].rst, vecs[n].fs, vecs[n].i0, vecs[n].i1, vecs[n].st, vecs[n].fl,
                  vecs[n].c1, vecs[n].r1, vecs[n].c2, vecs[n].r2);
            chk_out($sformatf("vec%0d", n), vecs[n].e1, vecs[n].e2, vecs[n].o1, vecs[n].o2, vecs[n].rdy);
        end

        // push into the last free entries while a pair pops
        drive(0, 0, IZ, IZ, 0, 0, 0, 0, 0, 0);
        drive(1, 3, IA, IB, 0, 0, 0, 0, 0, 0);
        drive(1, 3, ID, IE, 0, 0, 0, 0, 0, 0);
        chk_out("pushpop", 1, 1, IA, IB, 1);
        drive(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0);
        chk_out("pushpop_drain", 1, 1, ID, IE, 1);

        // set of $3 at issue wins over a same-cycle writeback of $3
        drive(0, 0, IZ, IZ, 0, 0, 0, 0, 0, 0);
        drive(1, 1, IA, IZ, 0, 0, 0, 0, 0, 0);
        drive(1, 0, IZ, IZ, 0, 0, 1, 3, 0, 0);
        chk_out("setwins_issue", 1, 0, IA, IZ, 1);
        drive(1, 1, IC, IZ, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0);
            chk_out($sformatf("setwins_hold%0d", k), 0, 0, IZ, IZ, 1);
        end
        drive(1, 0, IZ, IZ, 0, 0, 1, 3, 0, 0);
        chk_out("setwins_clr", 0, 0, IZ, IZ, 1);
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            drive(1, 0, IZ, IZ, 0, 0, 0, 0, 0, 0);
            if (ce1) begin
                found = 1'b1;
                chk("setwins_release_instr", es1, IC);
                chk("setwins_release_latency", 32'(k), 32'd0);
            end
        end
        chk("setwins_release_seen", 32'(found), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
